control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired control unit for the 32-bit bus datapath. It generates every datapath strobe cycle by cycle: fetch, decode of IR, and execute for ALU register ops, load/store and halt. Memory accesses wait on a done handshake. It replaces the hand-scripted T0..Tn control stimulus, so the datapath runs instruction streams from memory autonomously.

Parameters:
- OPC_W, 5, opcode field width (IR[31:27])
- ALU_OP_W, 4, width of alu_op output

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- ir  in  32  instruction register contents: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0]
- mem_done  in  1  memory function complete; sampled at posedge while Read or Write is high
- PCout, Zlowout, MDRout, Cout  out  1 each  bus drive strobes
- MARin, PCin, MDRin, IRin, Yin, Zin  out  1 each  register load strobes
- IncPC  out  1  ALU computes PC+1 in T0
- Read, Write  out  1 each  memory request; MDRin with Read=0 loads from bus
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/encode controls
- alu_op  out  ALU_OP_W  ALU function, valid while Zin=1
- run  out  1  high while executing; low in reset and HALT

Behaviour:
- Moore FSM. Outputs decode from the state register only and change one cycle after each posedge transition. Every strobe not listed for a state is 0.
- Reset: when reset is high at a posedge, next state is RST. In RST all outputs are 0, including run and alu_op=0. Reset overrides any state, including mid-memory-wait and HALT. The cycle after reset deasserts is RST; T0 follows.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin, alu_op=ALU_ADD.
  - T1: Zlowout, PCin, Read, MDRin. Go to T2 if mem_done, else T1W.
  - T1W: Read, MDRin. Hold until mem_done, then T2.
  - T2: MDRout, IRin.
  - T3 dispatches on ir[31:27], sampled in T3 after IR has loaded.
- ALU ops (ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op per opcode.
  - T5: Zlowout, Gra, Rin. Then T0.
- LD 00000:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, ALU_ADD.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; wait on mem_done.
  - T7: MDRout, Gra, Rin. Then T0.
- ST 00001:
  - T3 to T5 as LD.
  - T6: Gra, Rout, MDRin (Read=0).
  - T7: Write; hold until mem_done. Then T0.
- NOP 11010: T3 goes directly to T0.
- HALT 11011: T3 goes to HALT. HALT holds all outputs 0 and run=0 until reset.
- Undefined opcodes behave as NOP.
- Latencies with mem_done asserted immediately: ALU op 6 cycles, LD 8, ST 8, NOP 4.
- mem_done outside T1, T1W, T6 (LD) and T7 (ST) is ignored.
- No outputs pulse during wait cycles except the held Read/MDRin or Write.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in T3 goes to HALT and raises an extra output illegal_op (1 bit). illegal_op stays 1 in HALT and clears on reset.
- Undefined: no illegal_op port; undefined opcodes behave as NOP.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode constants (OPC_LD, OPC_ST, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHL, OPC_NOP, OPC_HALT)
  - ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SHR=4, ALU_SHL=5
  - state encoding constants (RST, T0, T1, T1W, T2..T7, HALT)
- Sub-module ctrl_decode: combinational map from opcode to {op class, alu_op}, instantiated once.

Test Plan:
- Reset held 3 cycles, then released with ir=0 -> outputs all 0 with run=0 during reset; T0 strobes (PCout, MARin, IncPC, Zin, alu_op=0) appear 2 cycles after release.
- ir=32'h2A2B8000 (AND R4,R5,R7), mem_done tied 1 -> T3 Grb+Rout+Yin; T4 Grc+Rout+Zin with alu_op=2; T5 Zlowout+Gra+Rin; back at T0 six cycles after T0.
- Fetch with mem_done low 3 cycles -> T1 once, T1W held 3 cycles with Read=MDRin=1 and PCin=0; T2 follows mem_done.
- LD (ir=32'h00800005), then ST (ir=32'h08800005), mem_done delayed 2 cycles -> LD: T6 Read held 3 cycles, T7 MDRout+Gra+Rin. ST: T6 Gra+Rout+MDRin with Read=0, T7 Write held until mem_done.
- HALT opcode 11011 -> run falls after T3 and all outputs stay 0 for 20 cycles; reset restarts at T0.
- reset asserted in T1W and in T6 -> next state RST with Read/Write dropped, no Rin pulse; with CTRL_ILLEGAL_TRAP_EN, opcode 11111 -> HALT and illegal_op=1 until reset.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// cpu_ctrl_pkg: opcodes, ALU function codes, FSM states and instruction classes
package cpu_ctrl_pkg;
  localparam logic [4:0] OPC_LD = 5'b00000, OPC_ST = 5'b00001, OPC_ADD = 5'b00011,
    OPC_SUB = 5'b00100, OPC_AND = 5'b00101, OPC_OR = 5'b00110, OPC_SHR = 5'b00111,
    OPC_SHL = 5'b01000, OPC_NOP = 5'b11010, OPC_HALT = 5'b11011;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_SHR = 4'd4, ALU_SHL = 4'd5;
  typedef enum logic [3:0] {RST, T0, T1, T1W, T2, T3, T4, T5, T6, T7, HALT} state_t;
  typedef enum logic [2:0] {CLS_NOP, CLS_ALU, CLS_LD, CLS_ST, CLS_HALT, CLS_ILL} cls_t;
endpackage

// File: rtl/control_sequencer_decode.sv
// ctrl_decode: maps an opcode to its instruction class and ALU function
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic [OPC_W-1:0]    opc,
  output cls_t                cls,
  output logic [ALU_OP_W-1:0] aop
);
  always_comb begin
    cls = CLS_ALU;
    aop = ALU_ADD;
    case (opc)
      OPC_ADD: aop = ALU_ADD;
      OPC_SUB: aop = ALU_SUB;
      OPC_AND: aop = ALU_AND;
      OPC_OR: aop = ALU_OR;
      OPC_SHR: aop = ALU_SHR;
      OPC_SHL: aop = ALU_SHL;
      OPC_LD: cls = CLS_LD;
      OPC_ST: cls = CLS_ST;
      OPC_NOP: cls = CLS_NOP;
      OPC_HALT: cls = CLS_HALT;
      default: cls = CLS_ILL;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control FSM for the 32-bit bus datapath.
// Define CTRL_ILLEGAL_TRAP_EN to halt on undefined opcodes and flag them on illegal_op.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         ir,
  input  logic                mem_done,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                Cout,
  output logic                MARin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                IncPC,
  output logic                Read,
  output logic                Write,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic [ALU_OP_W-1:0] alu_op,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                illegal_op,
`endif
  output logic                run
);
  state_t state;
  cls_t dec_cls, cls_q;
  logic [2:0] cls;
  logic [ALU_OP_W-1:0] dec_aop, aop_q;
  logic alu, ld, st, ldst, exe, unused_ir;
  ctrl_decode #(.OPC_W(OPC_W), .ALU_OP_W(ALU_OP_W)) u_dec (
    .opc(ir[31-:OPC_W]),
    .cls(dec_cls),
    .aop(dec_aop)
  );
  assign unused_ir = ^ir[31-OPC_W:0];
  // T3 dispatches on the freshly loaded IR; later execute states use the class latched in T3
  assign cls = state == T3 ? dec_cls : cls_q;
  assign alu = cls == CLS_ALU;
  assign ld = cls == CLS_LD;
  assign st = cls == CLS_ST;
  assign ldst = ld | st;
  assign exe = alu | ldst;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST;
      cls_q <= CLS_NOP;
      aop_q <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_op <= 1'b0;
`endif
    end else begin
      if (state == T3) begin
        cls_q <= dec_cls;
        aop_q <= dec_aop;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_op <= illegal_op | (state == T3 && dec_cls == CLS_ILL);
`endif
      case (state)
        RST: state <= T0;
        T0: state <= T1;
        T1, T1W: state <= mem_done ? T2 : T1W;
        T2: state <= T3;
`ifdef CTRL_ILLEGAL_TRAP_EN
        T3: state <= dec_cls inside {CLS_ALU, CLS_LD, CLS_ST} ? T4 :
                     dec_cls inside {CLS_HALT, CLS_ILL} ? HALT : T0;
`else
        T3: state <= dec_cls inside {CLS_ALU, CLS_LD, CLS_ST} ? T4 :
                     dec_cls == CLS_HALT ? HALT : T0;
`endif
        T4: state <= T5;
        T5: state <= cls_q == CLS_ALU ? T0 : T6;
        T6: state <= (cls_q == CLS_ST || mem_done) ? T7 : T6;
        T7: state <= (cls_q == CLS_LD || mem_done) ? T0 : T7;
        default: state <= HALT;
      endcase
    end
  end
  assign PCout = state == T0;
  assign IncPC = state == T0;
  assign Zlowout = state == T1 || state == T5;
  assign PCin = state == T1;
  assign MDRout = state == T2 || (state == T7 && ld);
  assign IRin = state == T2;
  assign Cout = state == T4 && ldst;
  assign MARin = state == T0 || (state == T5 && ldst);
  assign MDRin = state == T1 || state == T1W || (state == T6 && ldst);
  assign Read = state == T1 || state == T1W || (state == T6 && ld);
  assign Write = state == T7 && st;
  assign Yin = state == T3 && exe;
  assign Grb = state == T3 && exe;
  assign BAout = state == T3 && ldst;
  assign Zin = state == T0 || (state == T4 && exe);
  assign Grc = state == T4 && alu;
  assign Rout = ((state == T3 || state == T4) && alu) || (state == T6 && st);
  assign Gra = (state == T5 && alu) || (state == T6 && st) || (state == T7 && ld);
  assign Rin = (state == T5 && alu) || (state == T7 && ld);
  assign alu_op = (state == T4 && alu) ? aop_q : ALU_ADD;
  assign run = state != RST && state != HALT;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench; each queued entry is the strobe vector expected in a
// cycle plus the mem_done/reset values driven into the posedge that ends that cycle.
module tb_control_sequencer;
  logic clk = 1'b0, reset = 1'b1, mem_done = 1'b0;
  logic [31:0] ir = '0;
  logic PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run;
  logic [3:0] alu_op;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_op;
`endif
  logic [23:0] obs;
  typedef struct {
    logic [23:0] vec;
    bit md;
    bit rst;
  } ent_t;
  ent_t sb[$];
  ent_t e;
  int vectors = 0, miscompares = 0;
  logic [8:0] alu_tbl[6] = '{9'b00011_0000, 9'b00100_0001, 9'b00101_0010,
                             9'b00110_0011, 9'b00111_0100, 9'b01000_0101};
  localparam logic [23:0] PCO = 24'd1 << 23, ZLO = 24'd1 << 22, MDO = 24'd1 << 21,
    CO = 24'd1 << 20, MAI = 24'd1 << 19, PCI = 24'd1 << 18, MDI = 24'd1 << 17,
    IRI = 24'd1 << 16, YI = 24'd1 << 15, ZI = 24'd1 << 14, INC = 24'd1 << 13,
    RD = 24'd1 << 12, WR = 24'd1 << 11, GRA = 24'd1 << 10, GRB = 24'd1 << 9,
    GRC = 24'd1 << 8, RI = 24'd1 << 7, RO = 24'd1 << 6, BAO = 24'd1 << 5, RUN = 24'd1 << 4;
  localparam logic [23:0] V_0 = '0, V_T0 = PCO | MAI | INC | ZI | RUN,
    V_T1 = ZLO | PCI | RD | MDI | RUN, V_T1W = RD | MDI | RUN, V_T2 = MDO | IRI | RUN,
    V_T3A = GRB | RO | YI | RUN, V_T3M = GRB | BAO | YI | RUN, V_T3N = RUN,
    V_T4A = GRC | RO | ZI | RUN, V_T4M = CO | ZI | RUN, V_T5A = ZLO | GRA | RI | RUN,
    V_T5M = ZLO | MAI | RUN, V_T6L = RD | MDI | RUN, V_T6S = GRA | RO | MDI | RUN,
    V_T7L = MDO | GRA | RI | RUN, V_T7S = WR | RUN;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset(reset), .ir(ir), .mem_done(mem_done),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_op(alu_op),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .run(run)
  );

  assign obs = {PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC,
                Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run, alu_op};

  task automatic put(input logic [23:0] vec, input bit md = 1'b1, input bit rst = 1'b0);
    sb.push_back('{vec, md, rst});
  endtask

  task automatic do_reset(input logic [31:0] instr);
    @(negedge clk);
    reset = 1'b1;
    mem_done = 1'b0;
    ir = instr;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    put(V_0, 1'b0, 1'b1);
    put(V_0, 1'b0, 1'b1);
    put(V_0, 1'b0, 1'b0);
    put(V_T0);
    put(V_T1);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e.vec) begin
        miscompares++;
        $display("FAIL reset[%0d] got %h want %h", i, obs, e.vec);
      end
      mem_done = e.md;
      reset = e.rst;
    end
  endtask

  task automatic test_alu;
    for (int k = 0; k < 6; k++) begin
      do_reset({alu_tbl[k][8:4], 4'd4, 4'd5, 4'd7, 15'd0});
      put(V_T0);
      put(V_T1);
      put(V_T2);
      put(V_T3A);
      put(V_T4A | {20'd0, alu_tbl[k][3:0]});
      put(V_T5A);
      put(V_T0);
      for (int i = 0; sb.size() > 0; i++) begin
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (obs !== e.vec) begin
          miscompares++;
          $display("FAIL alu%0d[%0d] got %h want %h", k, i, obs, e.vec);
        end
        mem_done = e.md;
        reset = e.rst;
      end
    end
  endtask

  task automatic test_fetch_wait;
    do_reset(32'hD000_0000);
    put(V_T0);
    put(V_T1, 1'b0);
    put(V_T1W, 1'b0);
    put(V_T1W, 1'b0);
    put(V_T1W, 1'b1);
    put(V_T2);
    put(V_T3N);
    put(V_T0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e.vec) begin
        miscompares++;
        $display("FAIL fetch_wait[%0d] got %h want %h", i, obs, e.vec);
      end
      mem_done = e.md;
      reset = e.rst;
    end
  endtask

  task automatic test_ld_st;
    for (int k = 0; k < 2; k++) begin
      do_reset(k == 0 ? 32'h0080_0005 : 32'h0880_0005);
      put(V_T0);
      put(V_T1);
      put(V_T2);
      put(V_T3M);
      put(V_T4M);
      put(V_T5M);
      if (k == 0) begin
        put(V_T6L, 1'b0);
        put(V_T6L, 1'b0);
        put(V_T6L, 1'b1);
        put(V_T7L, 1'b0);
      end else begin
        put(V_T6S, 1'b0);
        put(V_T7S, 1'b0);
        put(V_T7S, 1'b0);
        put(V_T7S, 1'b1);
      end
      put(V_T0);
      for (int i = 0; sb.size() > 0; i++) begin
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (obs !== e.vec) begin
          miscompares++;
          $display("FAIL %s[%0d] got %h want %h", k == 0 ? "ld" : "st", i, obs, e.vec);
        end
        mem_done = e.md;
        reset = e.rst;
      end
    end
  endtask

  task automatic test_halt;
    do_reset(32'hD800_0000);
    put(V_T0);
    put(V_T1);
    put(V_T2);
    put(V_T3N);
    repeat (20) put(V_0);
    put(V_0, 1'b0, 1'b1);
    put(V_0, 1'b0, 1'b0);
    put(V_T0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e.vec) begin
        miscompares++;
        $display("FAIL halt[%0d] got %h want %h", i, obs, e.vec);
      end
      mem_done = e.md;
      reset = e.rst;
    end
  endtask

  task automatic test_reset_mid;
    do_reset(32'h0080_0005);
    put(V_T0);
    put(V_T1, 1'b0);
    put(V_T1W, 1'b0, 1'b1);
    put(V_0, 1'b1, 1'b0);
    put(V_T0);
    put(V_T1);
    put(V_T2);
    put(V_T3M);
    put(V_T4M);
    put(V_T5M);
    put(V_T6L, 1'b0, 1'b1);
    put(V_0, 1'b1, 1'b0);
    put(V_T0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e.vec) begin
        miscompares++;
        $display("FAIL reset_mid[%0d] got %h want %h", i, obs, e.vec);
      end
      mem_done = e.md;
      reset = e.rst;
    end
  endtask

`ifdef CTRL_ILLEGAL_TRAP_EN
  task automatic test_illegal;
    do_reset(32'hF800_0000);
    vectors++;
    if (illegal_op !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_clear got %b want 0", illegal_op);
    end
    put(V_T0);
    put(V_T1);
    put(V_T2);
    put(V_T3N);
    repeat (3) put(V_0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e.vec) begin
        miscompares++;
        $display("FAIL illegal[%0d] got %h want %h", i, obs, e.vec);
      end
      mem_done = e.md;
      reset = e.rst;
    end
    vectors++;
    if (illegal_op !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_set got %b want 1", illegal_op);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (illegal_op !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_reset got %b want 0", illegal_op);
    end
    reset = 1'b0;
  endtask
`else
  task automatic test_illegal;
    do_reset(32'hF800_0000);
    put(V_T0);
    put(V_T1);
    put(V_T2);
    put(V_T3N);
    put(V_T0);
    put(V_T1);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e.vec) begin
        miscompares++;
        $display("FAIL undefined_nop[%0d] got %h want %h", i, obs, e.vec);
      end
      mem_done = e.md;
      reset = e.rst;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_alu;
    test_fetch_wait;
    test_ld_st;
    test_halt;
    test_reset_mid;
    test_illegal;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
